lap_display_ctrl: RTL and testbench
===================================

Name: lap_display_ctrl

Overview:
- Display-selection controller for the stopwatch, successor to the single-lap display selector.
- Captures up to NUM_LAPS split times into a ring buffer and shows a new split for a programmable hold time.
- Lets the user browse stored laps, newest to oldest.
- Drives six BCD digits to the 7-segment decoders in either centisec/sec/min or sec/min/hr format.

Parameters:
HOLD_TICKS, 500, clk cycles a fresh split stays on the display (5 s at 100 Hz); legal range >= 1
NUM_LAPS, 8, ring-buffer depth; power of two, 2..16
IDX_W, 4, width of lap index/count outputs; must satisfy 2^IDX_W > NUM_LAPS

Ports:
clk  in  1  system clock, 100 Hz
rst_n  in  1  synchronous active-low reset
key  in  1  format toggle, level (debounced upstream)
parziale  in  1  split/lap capture, level
recall  in  1  browse stored laps, level
clear  in  1  erase lap memory, level
centisec  in  7  live centiseconds 0..99
sec  in  6  live seconds 0..59
min  in  6  live minutes 0..59
hr  in  5  live hours 0..23
disp0..disp5  out  4 each  BCD digits; disp0 = least significant
lap_idx  out  IDX_W  ordinal of the displayed lap, 1 = newest; 0 when live
lap_count  out  IDX_W  number of laps stored, 0..NUM_LAPS
show_lap  out  1  high when disp* shows a stored value, not live time

Behaviour:
- Everything is on posedge clk. rst_n low at an edge clears all of the following:
  - state to LIVE; mode to 0; wr_ptr, lap_count, lap_idx, hold_cnt to 0
  - edge-detect registers to 0; disp0..5 to 0; show_lap to 0
  - lap storage contents are don't-care.
- Edge detection:
  - key, parziale, recall and clear each act only on the 0->1 transition, giving a one-cycle internal pulse.
  - A held level does nothing further.
- mode toggles on each key pulse, in any state.
  - mode 0: disp5..0 = min tens/units, sec tens/units, centisec tens/units.
  - mode 1: disp5..0 = hr, min, sec, each as tens/units.
  - Tens digit = value/10; units digit = value%10.
- disp* and show_lap are registered, with one cycle of latency from the selected source (live inputs or stored lap).
- Capture, triggered by a parziale pulse in any state:
  - Write {centisec, sec, min, hr} sampled that cycle into slot wr_ptr.
  - wr_ptr increments modulo NUM_LAPS.
  - lap_count saturates at NUM_LAPS; once full, the oldest lap is overwritten.
  - Next state is HOLD, with hold_cnt = 0 and displayed slot = newly written slot.
- State LIVE: show live time; show_lap = 0; lap_idx = 0.
- State HOLD:
  - Show the held slot; show_lap = 1; lap_idx = 1.
  - hold_cnt increments each cycle; at hold_cnt == HOLD_TICKS-1 go to LIVE.
  - A new parziale pulse recaptures and restarts hold_cnt at 0.
  - A recall pulse goes to RECALL showing lap 2 if lap_count >= 2; otherwise it goes to LIVE.
- State RECALL:
  - Show slot (wr_ptr - lap_idx) mod NUM_LAPS; show_lap = 1.
  - There is no timeout.
  - A recall pulse increments lap_idx. If lap_idx == lap_count, go to LIVE instead.
- Recall pulse in LIVE:
  - With lap_count > 0, go to RECALL with lap_idx = 1.
  - With lap_count == 0, ignored.
- Clear pulse:
  - lap_count = 0, wr_ptr = 0, state LIVE, lap_idx = 0.
  - Highest priority: a simultaneous parziale or recall is ignored.
- Priority in one cycle: rst_n > clear > parziale > recall. A key pulse is independent and applies in the same cycle as any of these.
- The live inputs are not range-checked; out-of-range values produce whatever /10 and %10 yield, truncated to 4 bits.

Test Plan:
- Reset, then live time 01:23:45.67 with mode 0 -> after 1 cycle disp5..0 = 2,3,4,5,6,7; show_lap = 0; lap_count = 0.
- Pulse parziale at 00:00:12.34, live time keeps running -> disp shows 00 12 34 for exactly HOLD_TICKS cycles, then live; lap_count = 1. Pulse key during the hold -> format switches to 00 00 12.
- Capture laps at sec = 1..10 with NUM_LAPS = 8 -> lap_count = 8. Recall from LIVE walks sec = 10,9,...,3 with lap_idx = 1..8; the 9th recall returns to LIVE.
- parziale and recall pulsed in the same cycle -> capture happens, state is HOLD, recall is ignored. clear and parziale in the same cycle -> lap_count = 0, state LIVE.
- parziale held high for 20 cycles -> exactly one capture.
- rst_n low for one cycle during RECALL -> next cycle state LIVE, all outputs 0, lap_count = 0.

Source files
------------

// File: rtl/lap_display_ctrl.sv
// lap_display_ctrl
//   Display-selection controller for the stopwatch. Captures split times
//   into a ring buffer, holds a fresh split on the display for HOLD_TICKS
//   cycles, lets the user browse stored laps newest to oldest, and drives
//   six BCD digits in either min/sec/centisec or hr/min/sec format.
//
// Ports
//   clk          system clock (100 Hz)
//   rst_n        synchronous active-low reset
//   key          format toggle, level; acts on rising edge
//   parziale     split capture, level; acts on rising edge
//   recall       browse stored laps, level; acts on rising edge
//   clear        erase lap memory, level; acts on rising edge
//   centisec/sec/min/hr   live time
//   disp0..disp5 BCD digits, disp0 least significant (registered)
//   lap_idx      ordinal of the displayed lap, 1 = newest, 0 when live
//   lap_count    number of laps stored
//   show_lap     high when the digits show a stored lap (registered)
//
// state  | meaning
// -------+-----------------------------------------------------------
// LIVE   | live time on the display
// HOLD   | freshly captured split shown until hold_cnt expires
// RECALL | browsing stored laps; lap_idx selects which one, no timeout

module lap_display_ctrl #(
    parameter int HOLD_TICKS = 500,
    parameter int NUM_LAPS   = 8,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    input  logic             parziale,
    input  logic             recall,
    input  logic             clear,
    input  logic [6:0]       centisec,
    input  logic [5:0]       sec,
    input  logic [5:0]       min,
    input  logic [4:0]       hr,
    output logic [3:0]       disp0,
    output logic [3:0]       disp1,
    output logic [3:0]       disp2,
    output logic [3:0]       disp3,
    output logic [3:0]       disp4,
    output logic [3:0]       disp5,
    output logic [IDX_W-1:0] lap_idx,
    output logic [IDX_W-1:0] lap_count,
    output logic             show_lap
);

    localparam int PTR_W = (NUM_LAPS > 1) ? $clog2(NUM_LAPS) : 1;
    localparam int HC_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_TICKS - 1);
    localparam logic [IDX_W-1:0] LAPS_MAX  = IDX_W'(NUM_LAPS);

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        HOLD   = 2'd1,
        RECALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic key_r, parz_r, recall_r, clear_r;
    logic key_p, parz_p, recall_p, clear_p;
    logic cap_en;

    // Lap slot layout: {centisec[6:0], sec[5:0], min[5:0], hr[4:0]}
    logic [23:0]      lap_mem [NUM_LAPS];
    logic [PTR_W-1:0] rd_slot;
    logic [23:0]      src;
    logic [6:0]       src_cs, src_sec, src_min, src_hr;
    logic [23:0]      digits_d;

    function automatic logic [3:0] tens(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] units(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    assign key_p    = key      & ~key_r;
    assign parz_p   = parziale & ~parz_r;
    assign recall_p = recall   & ~recall_r;
    assign clear_p  = clear    & ~clear_r;

    // Clear outranks capture, so a simultaneous clear leaves memory untouched.
    assign cap_en = rst_n & parz_p & ~clear_p;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        mode_d     = mode_q ^ key_p;

        if (clear_p) begin
            state_d    = LIVE;
            wr_ptr_d   = '0;
            count_d    = '0;
            idx_d      = '0;
            hold_cnt_d = '0;
        end else if (parz_p) begin
            state_d    = HOLD;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            idx_d      = IDX_W'(1);
            hold_cnt_d = '0;
            if (count_q != LAPS_MAX)
                count_d = count_q + IDX_W'(1);
        end else if (recall_p) begin
            hold_cnt_d = '0;
            unique case (state_q)
                LIVE: begin
                    if (count_q != '0) begin
                        state_d = RECALL;
                        idx_d   = IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (count_q >= IDX_W'(2)) begin
                        state_d = RECALL;
                        idx_d   = IDX_W'(2);
                    end else begin
                        state_d = LIVE;
                        idx_d   = '0;
                    end
                end
                RECALL: begin
                    if (idx_q == count_q) begin
                        state_d = LIVE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = LIVE;
                    idx_d   = '0;
                end
            endcase
        end else if (state_q == HOLD) begin
            if (hold_cnt_q == HOLD_LAST) begin
                state_d    = LIVE;
                idx_d      = '0;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
        end
    end

    // HOLD always has lap_idx = 1, so one subtraction serves both views.
    assign rd_slot = wr_ptr_q - idx_q[PTR_W-1:0];

    always_comb begin
        src = {centisec, sec, min, hr};
        if (state_q != LIVE)
            src = lap_mem[rd_slot];
        src_cs  = src[23:17];
        src_sec = {1'b0, src[16:11]};
        src_min = {1'b0, src[10:5]};
        src_hr  = {2'b00, src[4:0]};
        if (mode_q)
            digits_d = {tens(src_hr), units(src_hr), tens(src_min), units(src_min),
                        tens(src_sec), units(src_sec)};
        else
            digits_d = {tens(src_min), units(src_min), tens(src_sec), units(src_sec),
                        tens(src_cs), units(src_cs)};
    end

    always_ff @(posedge clk) begin
        if (cap_en)
            lap_mem[wr_ptr_q] <= {centisec, sec, min, hr};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LIVE;
            mode_q     <= 1'b0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            key_r      <= 1'b0;
            parz_r     <= 1'b0;
            recall_r   <= 1'b0;
            clear_r    <= 1'b0;
            {disp5, disp4, disp3, disp2, disp1, disp0} <= '0;
            show_lap   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            key_r      <= key;
            parz_r     <= parziale;
            recall_r   <= recall;
            clear_r    <= clear;
            {disp5, disp4, disp3, disp2, disp1, disp0} <= digits_d;
            show_lap   <= (state_q != LIVE);
        end
    end

    assign lap_idx   = idx_q;
    assign lap_count = count_q;

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Directed bench for lap_display_ctrl: inputs change 1 ns after a rising
// edge and outputs are checked at that same point, so each tick() shows the
// result of exactly one clock edge.

module tb_lap_display_ctrl;

    localparam int HT = 12;

    logic       clk = 1'b0;
    logic       rst_n, key, parziale, recall, clear;
    logic [6:0] centisec;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic [3:0] disp0, disp1, disp2, disp3, disp4, disp5;
    logic [3:0] lap_idx, lap_count;
    logic       show_lap;
    logic [23:0] dw;

    int n_cmp = 0;
    int n_bad = 0;

    lap_display_ctrl #(.HOLD_TICKS(HT), .NUM_LAPS(8), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .parziale(parziale),
        .recall(recall), .clear(clear), .centisec(centisec), .sec(sec),
        .min(min), .hr(hr), .disp0(disp0), .disp1(disp1), .disp2(disp2),
        .disp3(disp3), .disp4(disp4), .disp5(disp5), .lap_idx(lap_idx),
        .lap_count(lap_count), .show_lap(show_lap)
    );

    always #5 clk = ~clk;

    assign dw = {disp5, disp4, disp3, disp2, disp1, disp0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s, input int cs);
        hr = 5'(h); min = 6'(m); sec = 6'(s); centisec = 7'(cs);
    endtask

    initial begin
        rst_n = 1'b0; key = 1'b0; parziale = 1'b0; recall = 1'b0; clear = 1'b0;
        set_time(0, 0, 0, 0);
        tick(2);
        chk("rst_disp", dw, 24'h000000);
        chk("rst_show", show_lap, 0);
        chk("rst_count", lap_count, 0);
        chk("rst_idx", lap_idx, 0);
        rst_n = 1'b1;

        // live display, mode 0
        set_time(1, 23, 45, 67);
        tick();
        chk("live_m0", dw, 24'h234567);
        chk("live_show", show_lap, 0);
        chk("live_count", lap_count, 0);

        // capture 00:00:12.34, hold for HT cycles
        set_time(0, 0, 12, 34);
        tick();
        parziale = 1'b1;
        tick();
        parziale = 1'b0;
        set_time(0, 0, 13, 0);
        for (int i = 1; i <= HT; i++) begin
            tick();
            chk($sformatf("hold_disp%0d", i), dw, 24'h001234);
            chk($sformatf("hold_show%0d", i), show_lap, 1);
        end
        chk("hold_idx", lap_idx, 0);
        tick();
        chk("hold_end_disp", dw, 24'h001300);
        chk("hold_end_show", show_lap, 0);
        chk("cnt_one", lap_count, 1);

        // key toggle during a hold
        set_time(0, 0, 12, 34);
        parziale = 1'b1;
        tick();
        parziale = 1'b0;
        set_time(0, 5, 6, 7);
        tick();
        chk("hold2_m0", dw, 24'h001234);
        chk("hold2_idx", lap_idx, 1);
        key = 1'b1;
        tick();
        key = 1'b0;
        tick();
        chk("hold2_m1", dw, 24'h000012);
        tick(HT);
        chk("live_m1", dw, 24'h000506);
        chk("live_m1_show", show_lap, 0);
        key = 1'b1;
        tick();
        key = 1'b0;
        tick();
        chk("live_back_m0", dw, 24'h050607);

        // fill the ring with sec = 1..10, then browse from LIVE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", lap_count, 0);
        for (int s = 1; s <= 10; s++) begin
            set_time(0, 0, s, 0);
            parziale = 1'b1;
            tick();
            parziale = 1'b0;
            tick();
        end
        chk("ring_count", lap_count, 8);
        set_time(0, 59, 55, 99);
        tick(HT + 2);
        chk("ring_live", show_lap, 0);
        for (int k = 1; k <= 8; k++) begin
            recall = 1'b1;
            tick();
            recall = 1'b0;
            tick();
            chk($sformatf("rc_idx%0d", k), lap_idx, k);
            chk($sformatf("rc_disp%0d", k), dw,
                ((11 - k) / 10) * 32'h1000 + ((11 - k) % 10) * 32'h100);
        end
        recall = 1'b1;
        tick();
        recall = 1'b0;
        tick();
        chk("rc_wrap_show", show_lap, 0);
        chk("rc_wrap_idx", lap_idx, 0);
        chk("rc_wrap_disp", dw, 24'h595599);

        // parziale + recall together: capture wins
        set_time(0, 0, 20, 0);
        parziale = 1'b1; recall = 1'b1;
        tick();
        parziale = 1'b0; recall = 1'b0;
        tick();
        chk("pr_show", show_lap, 1);
        chk("pr_idx", lap_idx, 1);
        chk("pr_disp", dw, 24'h002000);
        chk("pr_count_sat", lap_count, 8);

        // clear + parziale together: clear wins
        clear = 1'b1; parziale = 1'b1;
        tick();
        clear = 1'b0; parziale = 1'b0;
        tick();
        chk("cp_count", lap_count, 0);
        chk("cp_show", show_lap, 0);
        chk("cp_idx", lap_idx, 0);

        // recall with no laps is ignored
        recall = 1'b1;
        tick();
        recall = 1'b0;
        tick();
        chk("rc_empty_show", show_lap, 0);

        // held parziale captures once
        set_time(0, 0, 30, 0);
        parziale = 1'b1;
        tick(20);
        parziale = 1'b0;
        tick();
        chk("held_count", lap_count, 1);
        chk("held_live", show_lap, 0);

        // single lap: one recall shows it, the next returns to live
        recall = 1'b1;
        tick();
        recall = 1'b0;
        tick();
        chk("one_idx", lap_idx, 1);
        chk("one_disp", dw, 24'h003000);
        recall = 1'b1;
        tick();
        recall = 1'b0;
        tick();
        chk("one_back_idx", lap_idx, 0);
        chk("one_back_show", show_lap, 0);

        // reset during RECALL
        recall = 1'b1;
        tick();
        recall = 1'b0;
        tick();
        chk("pre_rst_show", show_lap, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_disp", dw, 24'h000000);
        chk("rst2_show", show_lap, 0);
        chk("rst2_count", lap_count, 0);
        chk("rst2_idx", lap_idx, 0);
        tick();
        chk("rst2_live", dw, 24'h003000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
